// File: rtl/decode_stage.sv
// decode_stage: instruction decode with register file, per-register
// pending-write scoreboard and a single execute output register.
// Optional feature: define DECODE_WB_BYPASS_EN to forward a same-cycle
// write-back into the decoded operands instead of stalling one cycle.
module decode_stage #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int PEND_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_vld,
  output logic            if_rdy,
  input  logic [31:0]     if_inst,
  input  logic [XLEN-1:0] if_pc,
  input  logic            wb_vld,
  input  logic [31:0]     wb_inst,
  input  logic [XLEN-1:0] wb_dat,
  input  logic            flush,
  output logic            ex_vld,
  input  logic            ex_rdy,
  output logic [31:0]     ex_inst,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_dat_a,
  output logic [XLEN-1:0] ex_dat_b,
  output logic [XLEN-1:0] ex_addr
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RR     = 7'b0110011;

  localparam logic [PEND_W:0] PEND_MAX = {1'b0, {PEND_W{1'b1}}};

  // An instruction writes a register unless it is a store/branch or targets x0.
  function automatic logic isWriter(input logic [31:0] inst);
    return (inst[6:0] != OP_STORE) && (inst[6:0] != OP_BRANCH) &&
           (inst[7 +: IW] != '0);
  endfunction

  logic [XLEN-1:0]   r_rf   [NREGS];
  logic [PEND_W-1:0] r_pend [NREGS];
  logic              r_exVld;
  logic [31:0]       r_exInst;
  logic [XLEN-1:0]   r_exPc, r_exDatA, r_exDatB, r_exAddr;

  logic [6:0]        w_opc;
  logic [IW-1:0]     w_rs1, w_rs2, w_rd, w_exRd, w_wbRd;
  logic              w_useRs1, w_useRs2, w_ifWriter, w_exWriter, w_wbWriter;
  logic              w_exInc, w_load, w_rdFull;
  logic              w_rs1Haz, w_rs2Haz, w_rs1ExHit, w_rs2ExHit;
  logic [PEND_W:0]   w_rdEffPend;
  logic [XLEN-1:0]   w_rs1Dat, w_rs2Dat, w_imm;
  logic signed [31:0] w_imm32;

  assign w_opc      = if_inst[6:0];
  assign w_rs1      = if_inst[15 +: IW];
  assign w_rs2      = if_inst[20 +: IW];
  assign w_rd       = if_inst[7 +: IW];
  assign w_exRd     = r_exInst[7 +: IW];
  assign w_wbRd     = wb_inst[7 +: IW];
  assign w_useRs1   = (w_opc != OP_LUI) && (w_opc != OP_AUIPC) && (w_opc != OP_JAL);
  assign w_useRs2   = (w_opc == OP_RR) || (w_opc == OP_STORE) || (w_opc == OP_BRANCH);
  assign w_ifWriter = isWriter(if_inst);
  assign w_exWriter = r_exVld && isWriter(r_exInst);
  assign w_wbWriter = wb_vld && isWriter(wb_inst);
  assign w_exInc    = w_exWriter && ex_rdy && !flush;

  assign w_rs1ExHit = w_exWriter && (w_exRd == w_rs1);
  assign w_rs2ExHit = w_exWriter && (w_exRd == w_rs2);

`ifdef DECODE_WB_BYPASS_EN
  logic w_rs1WbHit, w_rs2WbHit;
  assign w_rs1WbHit = w_wbWriter && (w_wbRd == w_rs1) && (r_pend[w_rs1] == PEND_W'(1));
  assign w_rs2WbHit = w_wbWriter && (w_wbRd == w_rs2) && (r_pend[w_rs2] == PEND_W'(1));
  assign w_rs1Haz = w_useRs1 && (w_rs1 != '0) &&
                    (w_rs1ExHit || ((r_pend[w_rs1] != '0) && !w_rs1WbHit));
  assign w_rs2Haz = w_useRs2 && (w_rs2 != '0) &&
                    (w_rs2ExHit || ((r_pend[w_rs2] != '0) && !w_rs2WbHit));
  assign w_rs1Dat = (w_rs1 == '0) ? '0 : (w_rs1WbHit ? wb_dat : r_rf[w_rs1]);
  assign w_rs2Dat = (w_rs2 == '0) ? '0 : (w_rs2WbHit ? wb_dat : r_rf[w_rs2]);
`else
  assign w_rs1Haz = w_useRs1 && (w_rs1 != '0) && (w_rs1ExHit || (r_pend[w_rs1] != '0));
  assign w_rs2Haz = w_useRs2 && (w_rs2 != '0) && (w_rs2ExHit || (r_pend[w_rs2] != '0));
  assign w_rs1Dat = (w_rs1 == '0) ? '0 : r_rf[w_rs1];
  assign w_rs2Dat = (w_rs2 == '0) ? '0 : r_rf[w_rs2];
`endif

  // The writer in the execute register has not been counted yet, so it is
  // added here; otherwise a fresh writer could be decoded behind it and the
  // counter would wrap when both reach execute acceptance.
  assign w_rdEffPend = {1'b0, r_pend[w_rd]} + {{PEND_W{1'b0}}, (w_exWriter && (w_exRd == w_rd))};
  assign w_rdFull    = w_ifWriter && (w_rdEffPend >= PEND_MAX);

  assign if_rdy = rst_n && !flush && (!r_exVld || ex_rdy) && !w_rs1Haz && !w_rs2Haz && !w_rdFull;
  assign w_load = if_vld && if_rdy;

  // Select and sign-extend the immediate format implied by the opcode.
  always_comb begin
    w_imm32 = {{20{if_inst[31]}}, if_inst[31:20]};
    case (w_opc)
      OP_LUI, OP_AUIPC: w_imm32 = {if_inst[31:12], 12'b0};
      OP_STORE:  w_imm32 = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
      OP_JAL:    w_imm32 = {{12{if_inst[31]}}, if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};
      OP_BRANCH: w_imm32 = {{20{if_inst[31]}}, if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
      default:   w_imm32 = {{20{if_inst[31]}}, if_inst[31:20]};
    endcase
  end

  assign w_imm = XLEN'(w_imm32);

  // Execute register: flush wins, then a new load, then drain on ex_rdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exVld  <= 1'b0;
      r_exInst <= '0;
      r_exPc   <= '0;
      r_exDatA <= '0;
      r_exDatB <= '0;
      r_exAddr <= '0;
    end else if (flush) begin
      r_exVld <= 1'b0;
    end else if (w_load) begin
      r_exVld  <= 1'b1;
      r_exInst <= if_inst;
      r_exPc   <= if_pc;
      r_exDatA <= w_rs1Dat;
      r_exDatB <= ((w_opc == OP_RR) || (w_opc == OP_STORE)) ? w_rs2Dat : w_imm;
      r_exAddr <= w_rs2Dat;
    end else if (ex_rdy) begin
      r_exVld <= 1'b0;
    end
  end

  // Register file written by write-back writers; x0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (w_wbWriter) begin
      r_rf[w_wbRd] <= wb_dat;
    end
  end

  // Pending counters: count up at execute acceptance, down at write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_pend[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if ((w_exInc && (w_exRd == IW'(i))) &&
            !(w_wbWriter && (w_wbRd == IW'(i)) && (r_pend[i] != '0)))
          r_pend[i] <= r_pend[i] + PEND_W'(1);
        else if (!(w_exInc && (w_exRd == IW'(i))) &&
                 (w_wbWriter && (w_wbRd == IW'(i)) && (r_pend[i] != '0)))
          r_pend[i] <= r_pend[i] - PEND_W'(1);
      end
    end
  end

  assign ex_vld   = r_exVld;
  assign ex_inst  = r_exInst;
  assign ex_pc    = r_exPc;
  assign ex_dat_a = r_exDatA;
  assign ex_dat_b = r_exDatB;
  assign ex_addr  = r_exAddr;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage
// (XLEN=32, NREGS=32, PEND_W=2), with expectations for both builds
// of the DECODE_WB_BYPASS_EN option.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        if_vld;
  logic        if_rdy;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        wb_vld;
  logic [31:0] wb_inst;
  logic [31:0] wb_dat;
  logic        flush;
  logic        ex_vld;
  logic        ex_rdy;
  logic [31:0] ex_inst;
  logic [31:0] ex_pc;
  logic [31:0] ex_dat_a;
  logic [31:0] ex_dat_b;
  logic [31:0] ex_addr;

  int errors = 0;
  int checks = 0;

  decode_stage #(.XLEN(32), .NREGS(32), .PEND_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_vld(if_vld), .if_rdy(if_rdy), .if_inst(if_inst), .if_pc(if_pc),
    .wb_vld(wb_vld), .wb_inst(wb_inst), .wb_dat(wb_dat),
    .flush(flush),
    .ex_vld(ex_vld), .ex_rdy(ex_rdy), .ex_inst(ex_inst), .ex_pc(ex_pc),
    .ex_dat_a(ex_dat_a), .ex_dat_b(ex_dat_b), .ex_addr(ex_addr)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rType(input int rd, input int rs1, input int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] iType(input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive the fetch side plus execute handshake and flush.
  task automatic applyStimulus(input logic vld, input logic [31:0] inst, input logic [31:0] pc,
                               input logic rdy, input logic fl);
    if_vld  = vld;
    if_inst = inst;
    if_pc   = pc;
    ex_rdy  = rdy;
    flush   = fl;
  endtask

  // Drive the write-back port; the rd field is carried by an ADDI encoding.
  task automatic setWb(input logic vld, input int rd, input logic [31:0] dat);
    wb_vld  = vld;
    wb_inst = iType(rd, 0, 0);
    wb_dat  = dat;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence.
  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    setWb(1'b0, 0, 32'h0);

    #12;
    checkOutput("reset if_rdy", {63'b0, if_rdy}, 64'h0);
    checkOutput("reset ex_vld", {63'b0, ex_vld}, 64'h0);
    checkOutput("reset ex_dat_a", {32'b0, ex_dat_a}, 64'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("post-reset if_rdy", {63'b0, if_rdy}, 64'h1);

    // Preload x1=5 and x2=7 through the write-back port.
    tick();
    setWb(1'b1, 1, 32'd5);
    tick();
    setWb(1'b1, 2, 32'd7);
    tick();
    setWb(1'b0, 0, 32'h0);

    // ADD x3,x1,x2 with execute stalled afterwards.
    applyStimulus(1'b1, rType(3, 1, 2), 32'h100, 1'b0, 1'b0);
    #1;
    checkOutput("add x3 if_rdy", {63'b0, if_rdy}, 64'h1);
    tick();
    checkOutput("add x3 ex_vld", {63'b0, ex_vld}, 64'h1);
    checkOutput("add x3 ex_dat_a", {32'b0, ex_dat_a}, 64'd5);
    checkOutput("add x3 ex_dat_b", {32'b0, ex_dat_b}, 64'd7);
    checkOutput("add x3 ex_pc", {32'b0, ex_pc}, 64'h100);

    // ADDI x4,x0,-1 waits three cycles behind a stalled execute register.
    applyStimulus(1'b1, iType(4, 0, -1), 32'h104, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("stall if_rdy", {63'b0, if_rdy}, 64'h0);
      tick();
      checkOutput("stall ex_inst", {32'b0, ex_inst}, {32'b0, rType(3, 1, 2)});
      checkOutput("stall ex_dat_a", {32'b0, ex_dat_a}, 64'd5);
      checkOutput("stall ex_vld", {63'b0, ex_vld}, 64'h1);
    end
    ex_rdy = 1'b1;
    #1;
    checkOutput("release if_rdy", {63'b0, if_rdy}, 64'h1);
    tick();
    checkOutput("addi x4 ex_dat_a", {32'b0, ex_dat_a}, 64'h0);
    checkOutput("addi x4 ex_dat_b", {32'b0, ex_dat_b}, 64'hFFFF_FFFF);
    checkOutput("addi x4 ex_pc", {32'b0, ex_pc}, 64'h104);

    // LUI x11,0x80000 then SW x2,4(x1).
    applyStimulus(1'b1, {20'h80000, 5'd11, 7'b0110111}, 32'h108, 1'b1, 1'b0);
    tick();
    checkOutput("lui ex_dat_b", {32'b0, ex_dat_b}, 64'h8000_0000);
    applyStimulus(1'b1, {7'b0, 5'd2, 5'd1, 3'b010, 5'd4, 7'b0100011}, 32'h10C, 1'b1, 1'b0);
    tick();
    checkOutput("sw ex_dat_a", {32'b0, ex_dat_a}, 64'd5);
    checkOutput("sw ex_dat_b", {32'b0, ex_dat_b}, 64'd7);
    checkOutput("sw ex_addr", {32'b0, ex_addr}, 64'd7);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("drain ex_vld", {63'b0, ex_vld}, 64'h0);

    // RAW hazard on x5 resolved by its write-back of 9.
    applyStimulus(1'b1, rType(5, 1, 2), 32'h110, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, rType(6, 5, 0), 32'h114, 1'b1, 1'b0);
    #1;
    checkOutput("raw ex-hit if_rdy", {63'b0, if_rdy}, 64'h0);
    tick();
    checkOutput("raw pending if_rdy", {63'b0, if_rdy}, 64'h0);
    tick();
    checkOutput("raw pending2 if_rdy", {63'b0, if_rdy}, 64'h0);
    setWb(1'b1, 5, 32'd9);
    #1;
`ifdef DECODE_WB_BYPASS_EN
    checkOutput("bypass if_rdy", {63'b0, if_rdy}, 64'h1);
    tick();
    setWb(1'b0, 0, 32'h0);
`else
    checkOutput("wb-cycle if_rdy", {63'b0, if_rdy}, 64'h0);
    tick();
    setWb(1'b0, 0, 32'h0);
    #1;
    checkOutput("after-wb if_rdy", {63'b0, if_rdy}, 64'h1);
    tick();
`endif
    checkOutput("raw ex_vld", {63'b0, ex_vld}, 64'h1);
    checkOutput("raw ex_pc", {32'b0, ex_pc}, 64'h114);
    checkOutput("raw ex_dat_a", {32'b0, ex_dat_a}, 64'd9);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();

    // Flush of a writer in the execute register.
    applyStimulus(1'b1, rType(8, 1, 2), 32'h118, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, iType(9, 0, 3), 32'h11C, 1'b1, 1'b1);
    #1;
    checkOutput("flush if_rdy", {63'b0, if_rdy}, 64'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("flush ex_vld", {63'b0, ex_vld}, 64'h0);
    applyStimulus(1'b1, rType(10, 8, 0), 32'h120, 1'b1, 1'b0);
    #1;
    checkOutput("flush no-pend if_rdy", {63'b0, if_rdy}, 64'h1);
    tick();
    checkOutput("flush next ex_pc", {32'b0, ex_pc}, 64'h120);
    checkOutput("flush next ex_dat_a", {32'b0, ex_dat_a}, 64'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();

    // Pending counter saturation on x7.
    applyStimulus(1'b1, iType(7, 0, 1), 32'h200, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, iType(7, 0, 1), 32'h204, 1'b1, 1'b0);
    #1;
    checkOutput("x7 w2 if_rdy", {63'b0, if_rdy}, 64'h1);
    tick();
    applyStimulus(1'b1, iType(7, 0, 1), 32'h208, 1'b1, 1'b0);
    #1;
    checkOutput("x7 w3 if_rdy", {63'b0, if_rdy}, 64'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, iType(7, 0, 1), 32'h20C, 1'b1, 1'b0);
    #1;
    checkOutput("x7 w4 full if_rdy", {63'b0, if_rdy}, 64'h0);
    tick();
    checkOutput("x7 w4 ex_vld", {63'b0, ex_vld}, 64'h0);
    setWb(1'b1, 7, 32'd1);
    tick();
    setWb(1'b0, 0, 32'h0);
    #1;
    checkOutput("x7 after wb if_rdy", {63'b0, if_rdy}, 64'h1);
    tick();
    checkOutput("x7 w4 loaded ex_vld", {63'b0, ex_vld}, 64'h1);
    checkOutput("x7 w4 ex_pc", {32'b0, ex_pc}, 64'h20C);

    // Asynchronous reset in the middle of a held instruction.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid-reset ex_vld", {63'b0, ex_vld}, 64'h0);
    checkOutput("mid-reset if_rdy", {63'b0, if_rdy}, 64'h0);
    checkOutput("mid-reset ex_inst", {32'b0, ex_inst}, 64'h0);
    #3;
    rst_n = 1'b1;
    applyStimulus(1'b1, rType(12, 1, 2), 32'h300, 1'b1, 1'b0);
    #1;
    checkOutput("post mid-reset if_rdy", {63'b0, if_rdy}, 64'h1);
    tick();
    checkOutput("cleared rf ex_dat_a", {32'b0, ex_dat_a}, 64'h0);
    checkOutput("cleared rf ex_dat_b", {32'b0, ex_dat_b}, 64'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
